// File: rtl/repeat_count_reporter.sv
// repeat_count_reporter
// Serialises the 10-bit repeated-word tally as a 4-byte UART-style frame:
// header, count high, count low, XOR checksum. A frame is sent on request or,
// when enabled, automatically whenever the tally differs from the last value sent.
// One further trigger that arrives while a frame is in flight is remembered, and
// produces exactly one follow-up frame.

module repeat_count_reporter #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          AUTO_REPORT  = 1,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  count_in,
    input  logic        report_req,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_reg;
    logic [TIMER_W-1:0]  timer_reg;
    logic [2:0]          bit_idx_reg;
    logic [1:0]          byte_idx_reg;
    logic [9:0]          shadow_reg;
    logic [9:0]          last_sent_reg;
    logic                pending_reg;
    logic                tx_reg;
    logic                busy_reg;
    logic                frame_done_reg;

    logic                auto_hit;
    logic                trigger;
    logic                bit_end;
    logic                in_flight;
    logic [2:0]          next_bit_idx;
    logic [7:0]          frame_byte [4];
    logic [7:0]          cur_byte;

    // Auto trigger compares against the value last latched into a frame, not the previous cycle
    assign auto_hit     = (AUTO_REPORT != 0) && (count_in != last_sent_reg);
    assign trigger      = report_req | auto_hit;
    assign bit_end      = (timer_reg == TIMER_LAST);
    assign in_flight    = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);
    assign next_bit_idx = bit_idx_reg + 3'd1;

    // Frame contents are built from the shadow copy so count_in may move freely mid-frame
    assign frame_byte[0] = HEADER;
    assign frame_byte[1] = {6'b0, shadow_reg[9:8]};
    assign frame_byte[2] = shadow_reg[7:0];
    assign frame_byte[3] = frame_byte[0] ^ frame_byte[1] ^ frame_byte[2];

    // Byte currently being shifted out
    always_comb begin
        cur_byte = frame_byte[byte_idx_reg];
    end

    // Frame sequencer: bit timing, byte walking, trigger capture and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            bit_idx_reg    <= '0;
            byte_idx_reg   <= '0;
            shadow_reg     <= '0;
            last_sent_reg  <= '0;
            pending_reg    <= 1'b0;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;

            // A trigger during transmission collapses into a single pending frame
            if (trigger && in_flight) begin
                pending_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (trigger) begin
                        shadow_reg    <= count_in;
                        last_sent_reg <= count_in;
                        timer_reg     <= '0;
                        bit_idx_reg   <= '0;
                        byte_idx_reg  <= '0;
                        tx_reg        <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= START;
                    end else begin
                        tx_reg   <= 1'b1;
                        busy_reg <= 1'b0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        timer_reg   <= '0;
                        bit_idx_reg <= '0;
                        tx_reg      <= cur_byte[0];
                        state_reg   <= DATA;
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        timer_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= next_bit_idx;
                            tx_reg      <= cur_byte[next_bit_idx];
                        end
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        timer_reg <= '0;
                        if (byte_idx_reg == 2'd3) begin
                            tx_reg         <= 1'b1;
                            frame_done_reg <= 1'b1;
                            state_reg      <= DONE;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                            tx_reg       <= 1'b0;
                            state_reg    <= START;
                        end
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end

                DONE: begin
                    // Back-to-back frame keeps busy high; the fresh value is latched here
                    if (pending_reg || trigger) begin
                        pending_reg   <= 1'b0;
                        shadow_reg    <= count_in;
                        last_sent_reg <= count_in;
                        timer_reg     <= '0;
                        bit_idx_reg   <= '0;
                        byte_idx_reg  <= '0;
                        tx_reg        <= 1'b0;
                        state_reg     <= START;
                    end else begin
                        tx_reg    <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_repeat_count_reporter.sv
// Bench for repeat_count_reporter: two instances (auto-report on and off) share
// stimulus; a time-based frame model predicts tx/busy/frame_done every cycle and
// serial receivers decode the line for hand-computed frame checks.

module tb_repeat_count_reporter;

    localparam int         CPB       = 4;
    localparam int         FRAME_CYC = 40 * CPB;
    localparam logic [7:0] HDR       = 8'hA5;

    logic       clk;
    logic       reset;
    logic [9:0] count_in;
    logic       report_req;
    logic       tx_a, busy_a, fd_a;
    logic       tx_m, busy_m, fd_m;

    int total;
    int bad;
    int cyc;
    int fdc_a;
    int fdc_m;

    logic [7:0] rxq_a [$];
    logic [7:0] rxq_m [$];

    typedef struct packed {
        logic        active;
        logic        done;
        logic        pending;
        logic [15:0] t;
        logic [9:0]  v;
        logic [9:0]  last;
    } mstate_t;

    mstate_t m_a;
    mstate_t m_m;

    repeat_count_reporter #(.CLKS_PER_BIT(CPB), .AUTO_REPORT(1), .HEADER(HDR)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .report_req (report_req),
        .tx         (tx_a),
        .busy       (busy_a),
        .frame_done (fd_a)
    );

    repeat_count_reporter #(.CLKS_PER_BIT(CPB), .AUTO_REPORT(0), .HEADER(HDR)) dut_m (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .report_req (report_req),
        .tx         (tx_m),
        .busy       (busy_m),
        .frame_done (fd_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Byte i of the frame that carries value v
    function automatic logic [7:0] mbyte(input logic [9:0] v, input int i);
        logic [7:0] b1;
        logic [7:0] b2;
        b1 = {6'b0, v[9:8]};
        b2 = v[7:0];
        case (i)
            0:       return HDR;
            1:       return b1;
            2:       return b2;
            default: return HDR ^ b1 ^ b2;
        endcase
    endfunction

    // Line level t cycles into a frame: 40 bit slots, 10 per byte (start, 8 data LSB first, stop)
    function automatic logic exp_tx(input mstate_t s);
        int k;
        int pos;
        logic [7:0] b;
        if (!s.active) return 1'b1;
        k   = int'(s.t) / CPB;
        pos = k % 10;
        b   = mbyte(s.v, k / 10);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    // One clock of the reporter described as: idle / frame running for t cycles / done cycle
    function automatic mstate_t mstep(input mstate_t s, input logic req,
                                      input logic [9:0] cnt, input bit auto_en);
        mstate_t n;
        logic trig;
        n    = s;
        trig = req | (auto_en && (cnt != s.last));
        if (s.active) begin
            if (trig) n.pending = 1'b1;
            n.t = s.t + 16'd1;
            if (n.t == 16'(FRAME_CYC)) begin
                n.active = 1'b0;
                n.done   = 1'b1;
            end
        end else if (s.done) begin
            n.done = 1'b0;
            if (s.pending || trig) begin
                n.pending = 1'b0;
                n.active  = 1'b1;
                n.t       = '0;
                n.v       = cnt;
                n.last    = cnt;
            end
        end else if (trig) begin
            n.active = 1'b1;
            n.t      = '0;
            n.v      = cnt;
            n.last   = cnt;
        end
        return n;
    endfunction

    function automatic logic sel_tx(input int idx);
        return (idx == 1) ? tx_a : tx_m;
    endfunction

    // Cycle counter
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reference model advance
    initial begin
        m_a = '0;
        m_m = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_a = '0;
                m_m = '0;
            end else begin
                m_a = mstep(m_a, report_req, count_in, 1'b1);
                m_m = mstep(m_m, report_req, count_in, 1'b0);
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("tx_a",   {31'b0, tx_a},   {31'b0, exp_tx(m_a)});
            chk("busy_a", {31'b0, busy_a}, {31'b0, m_a.active | m_a.done});
            chk("fd_a",   {31'b0, fd_a},   {31'b0, m_a.done});
            chk("tx_m",   {31'b0, tx_m},   {31'b0, exp_tx(m_m)});
            chk("busy_m", {31'b0, busy_m}, {31'b0, m_m.active | m_m.done});
            chk("fd_m",   {31'b0, fd_m},   {31'b0, m_m.done});
        end
    end

    // frame_done pulse counters
    initial begin
        fdc_a = 0;
        fdc_m = 0;
        forever begin
            @(negedge clk);
            if (fd_a) fdc_a++;
            if (fd_m) fdc_m++;
        end
    end

    // Serial receiver: detects a start bit, samples each following bit once per bit period
    task automatic rx_loop(input int idx);
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (sel_tx(idx) == 1'b0) begin
                b = '0;
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    b[j] = sel_tx(idx);
                end
                repeat (CPB) @(negedge clk);
                if (idx == 1) rxq_a.push_back(b);
                else          rxq_m.push_back(b);
                $display("rx dut_%s byte=%02h stop=%0b cycle=%0d",
                         (idx == 1) ? "a" : "m", b, sel_tx(idx), cyc);
            end
        end
    endtask

    initial begin
        fork
            rx_loop(1);
            rx_loop(0);
        join_none
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] q_at(input int idx, input int pos);
        if (idx == 1) return (pos < rxq_a.size()) ? {24'b0, rxq_a[pos]} : 32'hDEAD;
        return (pos < rxq_m.size()) ? {24'b0, rxq_m[pos]} : 32'hDEAD;
    endfunction

    task automatic chk_frame(input string nm, input int idx, input int base,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        chk({nm, "_b0"}, q_at(idx, base + 0), {24'b0, b0});
        chk({nm, "_b1"}, q_at(idx, base + 1), {24'b0, b1});
        chk({nm, "_b2"}, q_at(idx, base + 2), {24'b0, b2});
        chk({nm, "_b3"}, q_at(idx, base + 3), {24'b0, b3});
    endtask

    initial begin
        int c0;
        int fd_cyc;
        int got;
        int fa0;
        int fm0;
        int low_a;
        int low_m;
        int r;

        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        count_in   = '0;
        report_req = 1'b0;

        // Model pins
        chk("model_b3_2c3", {24'b0, mbyte(10'h2C3, 3)}, 32'h64);
        chk("model_b3_3ff", {24'b0, mbyte(10'h3FF, 3)}, 32'h59);

        // 1: reset, then idle with no trigger
        tick(3);
        chk("t1_reset_tx",   {31'b0, tx_a},   32'd1);
        chk("t1_reset_busy", {31'b0, busy_a}, 32'd0);
        reset = 1'b0;
        tick(6);
        chk("t1_idle_tx",   {31'b0, tx_a},   32'd1);
        chk("t1_idle_busy", {31'b0, busy_a}, 32'd0);
        chk("t1_idle_fd",   {31'b0, fd_a},   32'd0);
        chk("t1_idle_busy_m", {31'b0, busy_m}, 32'd0);

        // 2: request with count 2C3, frame timing and contents
        count_in   = 10'h2C3;
        report_req = 1'b1;
        c0         = cyc;
        tick(1);
        report_req = 1'b0;
        got    = 0;
        fd_cyc = 0;
        for (int i = 0; i < 400 && got == 0; i++) begin
            @(negedge clk);
            if (fd_a) begin
                got    = 1;
                fd_cyc = cyc;
            end
        end
        chk("t2_fd_seen", got, 32'd1);
        chk("t2_fd_latency", fd_cyc - (c0 + 1), FRAME_CYC);
        @(posedge clk);
        #1;
        tick(2);
        chk("t2_busy_low_a", {31'b0, busy_a}, 32'd0);
        chk("t2_busy_low_m", {31'b0, busy_m}, 32'd0);
        chk("t2_nbytes_a", rxq_a.size(), 32'd4);
        chk_frame("t2_a", 1, 0, 8'hA5, 8'h02, 8'hC3, 8'h64);
        chk_frame("t2_m", 0, 0, 8'hA5, 8'h02, 8'hC3, 8'h64);

        // 3: auto report on a 0 -> 1 step, then silence while stable
        count_in = 10'h000;
        tick(400);
        rxq_a.delete();
        rxq_m.delete();
        fa0 = fdc_a;
        fm0 = fdc_m;
        count_in = 10'h001;
        tick(600);
        chk("t3_frames_a", fdc_a - fa0, 32'd1);
        chk("t3_frames_m", fdc_m - fm0, 32'd0);
        chk("t3_nbytes_a", rxq_a.size(), 32'd4);
        chk_frame("t3_a", 1, 0, 8'hA5, 8'h00, 8'h01, 8'hA4);

        // 4: mid-frame change and three requests collapse into one follow-up frame
        rxq_a.delete();
        rxq_m.delete();
        fa0 = fdc_a;
        fm0 = fdc_m;
        report_req = 1'b1;
        tick(1);
        report_req = 1'b0;
        tick(30);
        count_in   = 10'h3FF;
        for (int p = 0; p < 3; p++) begin
            report_req = 1'b1;
            tick(1);
            report_req = 1'b0;
            tick(20);
        end
        low_a = 0;
        low_m = 0;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (!busy_a) low_a++;
            if (!busy_m) low_m++;
        end
        chk("t4_busy_gap_a", low_a, 32'd0);
        chk("t4_busy_gap_m", low_m, 32'd0);
        @(posedge clk);
        #1;
        tick(200);
        chk("t4_frames_a", fdc_a - fa0, 32'd2);
        chk("t4_frames_m", fdc_m - fm0, 32'd2);
        chk("t4_nbytes_a", rxq_a.size(), 32'd8);
        chk_frame("t4_first_a",  1, 0, 8'hA5, 8'h00, 8'h01, 8'hA4);
        chk_frame("t4_second_a", 1, 4, 8'hA5, 8'h03, 8'hFF, 8'h59);
        chk_frame("t4_second_m", 0, 4, 8'hA5, 8'h03, 8'hFF, 8'h59);

        // 5: reset at data bit 5 of byte 1
        fa0 = fdc_a;
        fm0 = fdc_m;
        report_req = 1'b1;
        tick(1);
        report_req = 1'b0;
        tick(65);
        reset    = 1'b1;
        count_in = 10'h000;
        #1;
        chk("t5_abort_tx_a",   {31'b0, tx_a},   32'd1);
        chk("t5_abort_busy_a", {31'b0, busy_a}, 32'd0);
        chk("t5_abort_tx_m",   {31'b0, tx_m},   32'd1);
        chk("t5_abort_busy_m", {31'b0, busy_m}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(300);
        chk("t5_no_residual_a", fdc_a - fa0, 32'd0);
        chk("t5_no_residual_m", fdc_m - fm0, 32'd0);
        chk("t5_idle_busy_a", {31'b0, busy_a}, 32'd0);
        rxq_a.delete();
        rxq_m.delete();

        // 6: manual-only instance ignores count changes until requested
        fm0 = fdc_m;
        count_in = 10'h155;
        tick(400);
        chk("t6_no_frame_m", fdc_m - fm0, 32'd0);
        chk("t6_no_bytes_m", rxq_m.size(), 32'd0);
        rxq_a.delete();
        rxq_m.delete();
        report_req = 1'b1;
        tick(1);
        report_req = 1'b0;
        tick(200);
        chk("t6_one_frame_m", fdc_m - fm0, 32'd1);
        chk("t6_nbytes_m", rxq_m.size(), 32'd4);
        chk_frame("t6_m", 0, 0, 8'hA5, 8'h01, 8'h55, 8'hF1);
        chk_frame("t6_repeat_a", 1, 0, 8'hA5, 8'h01, 8'h55, 8'hF1);

        // Randomised traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)      count_in = 10'($urandom);
            else if (r < 5) count_in = count_in ^ 10'd1;
            report_req = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
            tick(1);
        end
        report_req = 1'b0;
        tick(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
